hc4_core: RTL and testbench

Parametrised successor of the HC4 stack-machine CPU. It keeps the 8-bit HC4-style instruction format and the shift-register operand stack, with three changes: stack depth and program-counter width are configurable; instruction and data memories are external, behind handshaked and synchronous ports; and a multi-cycle FSM adds wait-state fetch, a halt instruction and stack-loss detection. It is the core the top level instantiates alongside the ROM and RAM blocks.

---
 rtl/hc4_core.sv | 193 +++++++++++++++++++
 tb/tb_hc4_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hc4_core.sv
// hc4_core: multi-cycle HC4-style stack-machine CPU.
// 8-bit instructions, shift-register operand stack, external handshaked
// instruction port and synchronous RAM port, with halt and stack-loss detection.
module hc4_core #(
  parameter int DATA_W      = 4,
  parameter int STACK_DEPTH = 3,
  parameter int PC_W        = 12,
  parameter int RAM_AW      = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic [7:0]        imem_data,
  input  logic              imem_valid,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [PC_W-1:0]   pc_out,
  output logic [7:0]        instruction_out,
  output logic [DATA_W-1:0] alu_out,
  output logic              carry_out,
  output logic              zero_out,
  output logic              stack_lost,
  output logic              halted
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_LOADW, ST_HALT} state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [7:0]        instr_q;
  logic [DATA_W-1:0] stack_q [STACK_DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic              carry_q;
  logic              zero_q;
  logic              lost_q;

  logic [3:0]          op;
  logic [3:0]          nib;
  logic                is_store;
  logic                is_ld;
  logic [2*DATA_W-1:0] ab_full;
  logic [3*DATA_W-1:0] jt_full;
  logic [DATA_W:0]     add_res;
  logic [DATA_W:0]     sub_res;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic                jmp_taken;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     jmp_pc_d;
  logic                push_en;
  logic [DATA_W-1:0]   push_val;

  assign op       = instr_q[7:4];
  assign nib      = instr_q[3:0];
  assign is_store = (op[3] == 1'b0) && (op != 4'h7);
  assign is_ld    = (op == 4'h8) || (op == 4'h9);
  assign ab_full  = {stack_q[1], stack_q[0]};
  assign jt_full  = {stack_q[2], stack_q[1], stack_q[0]};
  assign pc_inc   = pc_q + PC_W'(1);

  // Subtraction is S0 + ~S1 + 1 so the carry-out reads as "no borrow".
  assign add_res = {1'b0, stack_q[0]} + {1'b0, stack_q[1]};
  assign sub_res = {1'b0, stack_q[0]} + {1'b0, ~stack_q[1]} + (DATA_W+1)'(1);

  // ALU result and carry selected by opcode; add is the default mode.
  always_comb begin
    alu_res   = add_res[DATA_W-1:0];
    alu_carry = add_res[DATA_W];
    case (op)
      4'h3: begin
        alu_res   = sub_res[DATA_W-1:0];
        alu_carry = sub_res[DATA_W];
      end
      4'h4: alu_res = stack_q[0] & stack_q[1];
      4'h5: alu_res = stack_q[0] | stack_q[1];
      4'h6: alu_res = stack_q[0] ^ stack_q[1];
      default: ;
    endcase
  end

  // Jump condition evaluated against the flags left by the previous instruction.
  always_comb begin
    case (nib[2:0])
      3'b000:  jmp_taken = 1'b1;
      3'b010:  jmp_taken = carry_q;
      3'b011:  jmp_taken = ~carry_q;
      3'b100:  jmp_taken = zero_q;
      3'b101:  jmp_taken = ~zero_q;
      default: jmp_taken = 1'b0;
    endcase
    jmp_pc_d = jmp_taken ? jt_full[PC_W-1:0] : pc_inc;
  end

  // RAM port: store data by opcode, address either [AB] or the r nibble.
  always_comb begin
    case (op)
      4'h0:    ram_wdata = stack_q[2];
      4'h1:    ram_wdata = stack_q[0];
      default: ram_wdata = alu_res;
    endcase
    if ((op == 4'h0) || (op == 4'h8)) ram_addr = ab_full[RAM_AW-1:0];
    else                              ram_addr = RAM_AW'(nib);
  end

  // Pushes come from LI in EXEC or from the returned RAM word in LOADW.
  always_comb begin
    push_en  = ((state_q == ST_EXEC) && (op == 4'hA)) || (state_q == ST_LOADW);
    push_val = (state_q == ST_LOADW) ? ram_rdata : DATA_W'(nib);
  end

  // Operand stack: shift down on every push, S0 takes the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STACK_DEPTH; k++) stack_q[k] <= '0;
    end else if (push_en) begin
      for (int k = 1; k < STACK_DEPTH; k++) stack_q[k] <= stack_q[k-1];
      stack_q[0] <= push_val;
    end
  end

  // Valid-level count saturates; a push at full depth loses the bottom level.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      lost_q  <= 1'b0;
    end else if (push_en) begin
      if (count_q == CNT_W'(STACK_DEPTH)) lost_q  <= 1'b1;
      else                                count_q <= count_q + CNT_W'(1);
    end
  end

  // Control FSM: fetch with wait states, execute, load wait, halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      instr_q <= 8'hE1;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_valid) begin
            instr_q <= imem_data;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_store) begin
            zero_q <= (ram_wdata == '0);
            if ((op == 4'h2) || (op == 4'h3)) carry_q <= alu_carry;
            pc_q    <= pc_inc;
            state_q <= ST_FETCH;
          end else if (is_ld) begin
            state_q <= ST_LOADW;
          end else if (op == 4'hF) begin
            state_q <= ST_HALT;
          end else if (op == 4'hE) begin
            pc_q    <= jmp_pc_d;
            state_q <= ST_FETCH;
          end else begin
            pc_q    <= pc_inc;
            state_q <= ST_FETCH;
          end
        end
        ST_LOADW: begin
          pc_q    <= pc_inc;
          state_q <= ST_FETCH;
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign imem_req        = (state_q == ST_FETCH);
  assign imem_addr       = pc_q;
  assign ram_we          = (state_q == ST_EXEC) && is_store && !reset;
  assign ram_re          = (state_q == ST_EXEC) && is_ld && !reset;
  assign pc_out          = pc_q;
  assign instruction_out = instr_q;
  assign alu_out         = alu_res;
  assign carry_out       = carry_q;
  assign zero_out        = zero_q;
  assign stack_lost      = lost_q;
  assign halted          = (state_q == ST_HALT);

endmodule

// File: tb/tb_hc4_core.sv
// Directed testbench for hc4_core with a ROM array and a synchronous RAM model.
module tb_hc4_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [11:0] imem_addr;
  logic       imem_req;
  logic [7:0] imem_data;
  logic       imem_valid;
  logic [7:0] ram_addr;
  logic [3:0] ram_wdata;
  logic       ram_we;
  logic       ram_re;
  logic [3:0] ram_rdata;
  logic [11:0] pc_out;
  logic [7:0] instruction_out;
  logic [3:0] alu_out;
  logic       carry_out;
  logic       zero_out;
  logic       stack_lost;
  logic       halted;

  logic [7:0] rom [4096];
  logic [3:0] ram [256];
  logic       poke_en;
  logic [7:0] poke_addr;
  logic [3:0] poke_data;

  int total;
  int bad;

  hc4_core dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_data(imem_data), .imem_valid(imem_valid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .pc_out(pc_out), .instruction_out(instruction_out), .alu_out(alu_out),
    .carry_out(carry_out), .zero_out(zero_out), .stack_lost(stack_lost), .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];

  // Synchronous RAM: write strobe or bench preload, read data one cycle later.
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input logic [7:0] a, input logic [3:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
  endtask

  task automatic rst_begin();
    reset = 1'b1;
    step(2);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; imem_valid = 1'b1;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;

    // LI 3; LI 5; ADD 0x2; HLT
    clear_rom();
    rom[0] = 8'hA3; rom[1] = 8'hA5; rom[2] = 8'h22;
    rst_begin();
    poke(8'h02, 4'hF);
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_instr", 32'(instruction_out), 32'hE1);
    chk("rst_flags", 32'({carry_out, zero_out, stack_lost, halted}), 32'h0);
    chk("rst_strobes", 32'({ram_we, ram_re}), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h1);
    reset = 1'b0;
    step(5);
    chk("add_we", 32'({ram_we, ram_re}), 32'h2);
    chk("add_addr", 32'(ram_addr), 32'h02);
    chk("add_wdata", 32'(ram_wdata), 32'h8);
    chk("add_alu", 32'(alu_out), 32'h8);
    step(1);
    chk("add_pc", 32'(pc_out), 32'h3);
    chk("add_ram", 32'(ram[2]), 32'h8);
    chk("add_cz", 32'({carry_out, zero_out}), 32'h0);
    step(2);
    chk("hlt_halted", 32'(halted), 32'h1);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("hlt_quiet", 32'({ram_we, ram_re, imem_req, halted}), 32'h1);
    end
    chk("hlt_pc", 32'(pc_out), 32'h3);

    // LI F; LI 1; ADD 3 (wraps to 0); LI 0 x3; JC -> 0
    clear_rom();
    rom[0] = 8'hAF; rom[1] = 8'hA1; rom[2] = 8'h23;
    rom[3] = 8'hA0; rom[4] = 8'hA0; rom[5] = 8'hA0; rom[6] = 8'hE2;
    rst_begin();
    poke(8'h03, 4'hA);
    reset = 1'b0;
    step(6);
    chk("wrap_ram", 32'(ram[3]), 32'h0);
    chk("wrap_cz", 32'({carry_out, zero_out}), 32'h3);
    step(6);
    chk("wrap_pc6", 32'(pc_out), 32'h6);
    chk("wrap_lost", 32'(stack_lost), 32'h1);
    step(2);
    chk("jc_pc", 32'(pc_out), 32'h0);

    // Four pushes, ST 1, ST [AB], HLT
    clear_rom();
    rom[0] = 8'hA1; rom[1] = 8'hA2; rom[2] = 8'hA3; rom[3] = 8'hA4;
    rom[4] = 8'h11; rom[5] = 8'h00;
    rst_begin();
    poke(8'h01, 4'h0);
    poke(8'h34, 4'h0);
    chk("lost_rst", 32'(stack_lost), 32'h0);
    reset = 1'b0;
    step(6);
    chk("lost_3push", 32'(stack_lost), 32'h0);
    step(2);
    chk("lost_4push", 32'(stack_lost), 32'h1);
    step(6);
    chk("lost_held", 32'(stack_lost), 32'h1);
    chk("st_r_ram", 32'(ram[1]), 32'h4);
    chk("st_ab_ram", 32'(ram[8'h34]), 32'h2);
    chk("st_halt", 32'({halted, zero_out}), 32'h2);
    rst_begin();
    chk("lost_cleared", 32'(stack_lost), 32'h0);

    // Fetch wait states, SUB with and without borrow, JZ not taken, JNC taken
    clear_rom();
    rom[0] = 8'hA7; rom[1] = 8'hA9; rom[2] = 8'h34; rom[3] = 8'hA3;
    rom[4] = 8'h35; rom[5] = 8'hE4; rom[6] = 8'hE3;
    reset = 1'b0;
    step(2);
    imem_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("stall_pc", 32'(pc_out), 32'h1);
      chk("stall_addr", 32'(imem_addr), 32'h1);
      chk("stall_instr", 32'(instruction_out), 32'hA7);
    end
    imem_valid = 1'b1;
    step(2);
    chk("resume_pc", 32'(pc_out), 32'h2);
    step(2);
    chk("sub_ram", 32'(ram[4]), 32'h2);
    chk("sub_cz", 32'({carry_out, zero_out}), 32'h2);
    step(4);
    chk("subb_ram", 32'(ram[5]), 32'hA);
    chk("subb_cz", 32'({carry_out, zero_out}), 32'h0);
    step(2);
    chk("jz_pc", 32'(pc_out), 32'h6);
    step(2);
    chk("jnc_pc", 32'(pc_out), 32'h793);

    // LI 1; LI 2; LD [AB]; ST 6; LD 7; ST 8; HLT
    clear_rom();
    rom[0] = 8'hA1; rom[1] = 8'hA2; rom[2] = 8'h80; rom[3] = 8'h16;
    rom[4] = 8'h97; rom[5] = 8'h18;
    rst_begin();
    poke(8'h12, 4'hC);
    poke(8'h07, 4'h5);
    reset = 1'b0;
    step(5);
    chk("ld_re", 32'({ram_we, ram_re}), 32'h1);
    chk("ld_addr", 32'(ram_addr), 32'h12);
    step(2);
    chk("ld_pc", 32'(pc_out), 32'h3);
    step(2);
    chk("ld_ab_val", 32'(ram[6]), 32'hC);
    step(5);
    chk("ld_r_val", 32'(ram[8]), 32'h5);
    chk("ld_pc_end", 32'(pc_out), 32'h6);

    // Reset gating in EXEC and reset during LOADW (no push)
    clear_rom();
    rom[0] = 8'h9A;
    rst_begin();
    poke(8'h0A, 4'h3);
    poke(8'h0B, 4'hF);
    reset = 1'b0;
    step(1);
    chk("exec_re", 32'(ram_re), 32'h1);
    reset = 1'b1;
    #1;
    chk("re_gated", 32'(ram_re), 32'h0);
    step(1);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    chk("loadw_rst_pc", 32'(pc_out), 32'h0);
    chk("loadw_rst_state", 32'({imem_req, halted}), 32'h2);
    chk("loadw_rst_instr", 32'(instruction_out), 32'hE1);
    rom[0] = 8'h1B;
    reset = 1'b0;
    step(2);
    chk("no_push_ram", 32'(ram[8'h0B]), 32'h0);
    chk("no_push_z", 32'(zero_out), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
